// File: rtl/nvdla_glb_intr_coalesce.sv
// Global interrupt controller: per-source done-pulse status capture, masking,
// software set/clear via a register port, and count/timeout interrupt coalescing.
module nvdla_glb_intr_coalesce #(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 8,
  parameter int TMR_W   = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [2*NUM_SRC-1:0]   src_done_intr_pd,
  input  logic                   req_pvld,
  output logic                   req_prdy,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [31:0]            req_wdat,
  input  logic                   req_write,
  input  logic                   req_nposted,
  output logic                   resp_valid,
  output logic [33:0]            resp_pd,
  output logic                   core_intr
);

  localparam int SW    = 2 * NUM_SRC;
  localparam int IW    = $clog2(SW + 1);
  localparam int SUM_W = ((CNT_W > IW) ? CNT_W : IW) + 1;

  localparam logic [ADDR_W-1:0] A_MASK     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SET      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COALESCE = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_EVCNT    = ADDR_W'(4);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};

  logic [SW-1:0]    status_q, status_d;
  logic [SW-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [TMR_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] evcnt_q, evcnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             intr_q, intr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [33:0]      resp_pd_q, resp_pd_d;

  logic             acc, wr;
  logic [SW-1:0]    sw_set, w1c_clear, new_evt;
  logic             pend, thr_hit, tmo_hit;
  logic [IW-1:0]    inc;
  logic [SUM_W-1:0] ev_sum;
  logic [31:0]      rdata;
  logic             err;

  function automatic logic [IW-1:0] popcount(input logic [SW-1:0] v);
    logic [IW-1:0] n;
    n = '0;
    for (int i = 0; i < SW; i++) n = n + IW'(v[i]);
    return n;
  endfunction

  assign req_prdy = 1'b1;
  assign acc      = req_pvld & req_prdy;
  assign wr       = acc & req_write;

  assign pend    = |(status_q & ~mask_q);
  // Only freshly arriving, unmasked events count; re-pulsing a set bit or unmasking does not.
  assign new_evt = src_done_intr_pd & ~mask_q & ~status_q;
  assign inc     = popcount(new_evt);
  assign ev_sum  = SUM_W'(pend ? evcnt_q : '0) + SUM_W'(inc);

  assign thr_hit = (thresh_q == '0) || (evcnt_q >= thresh_q);
  assign tmo_hit = (tmo_q != '0) && (timer_q >= tmo_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    sw_set    = '0;
    w1c_clear = '0;
    mask_d    = mask_q;
    thresh_d  = thresh_q;
    tmo_d     = tmo_q;
    if (wr) begin
      case (req_addr)
        A_MASK:     mask_d    = req_wdat[SW-1:0];
        A_SET:      sw_set    = req_wdat[SW-1:0];
        A_STATUS:   w1c_clear = req_wdat[SW-1:0];
        A_COALESCE: begin
          thresh_d = req_wdat[CNT_W-1:0];
          tmo_d    = req_wdat[16 +: TMR_W];
        end
        default: ;
      endcase
    end

    status_d = (status_q & ~w1c_clear) | src_done_intr_pd | sw_set;
    evcnt_d  = (ev_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ev_sum[CNT_W-1:0];
    timer_d  = !pend ? '0 : ((timer_q == TMR_MAX) ? TMR_MAX : timer_q + TMR_W'(1));
    // Once raised, the interrupt is held for as long as anything unmasked is pending.
    intr_d   = pend && (intr_q || thr_hit || tmo_hit);
  end

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (req_addr)
      A_MASK:     rdata[SW-1:0] = mask_q;
      A_SET:      rdata         = '0;
      A_STATUS:   rdata[SW-1:0] = status_q;
      A_COALESCE: begin
        rdata[CNT_W-1:0]   = thresh_q;
        rdata[16 +: TMR_W] = tmo_q;
      end
      A_EVCNT:    rdata[CNT_W-1:0] = evcnt_q;
      default:    err = 1'b1;
    endcase

    resp_valid_d = acc && (!req_write || req_nposted);
    resp_pd_d    = resp_valid_d ? {err, req_write, (req_write ? 32'h0 : rdata)} : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      status_q     <= '0;
      mask_q       <= '0;
      thresh_q     <= '0;
      tmo_q        <= '0;
      evcnt_q      <= '0;
      timer_q      <= '0;
      intr_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= '0;
    end else begin
      status_q     <= status_d;
      mask_q       <= mask_d;
      thresh_q     <= thresh_d;
      tmo_q        <= tmo_d;
      evcnt_q      <= evcnt_d;
      timer_q      <= timer_d;
      intr_q       <= intr_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_pd    = resp_pd_q;
  assign core_intr  = intr_q;

endmodule
